// File: rtl/axis_mem_cmd_pkg.sv
// Shared types for axis_mem_cmd: request header layout, MIG command codes, FSM states.
package axis_mem_cmd_pkg;

    localparam int APP_ADDR_W = 27;

    typedef struct packed {
        logic [APP_ADDR_W-1:0] addr;
        logic [APP_ADDR_W-1:0] stream_length;
        logic                  wen;
    } channel_update_t;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

endpackage

// File: rtl/axis_mem_cmd_sync_fifo.sv
// Registered single-clock FIFO; data visible one cycle after push.
// Pushes while full are dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/axis_mem_cmd.sv
// AXI-stream request to MIG UI command converter with credit-limited read return FIFO.
// Writes pass through in zero cycles; read data reaches resp_axis one cycle after MIG return. MEM_WRITE_ACK_EN adds a write-done response beat.
module axis_mem_cmd
    import axis_mem_cmd_pkg::*;
#(
    parameter int RD_FIFO_DEPTH = 16,
    parameter int ADDR_SHIFT    = 3
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         req_axis_valid,
    output logic         req_axis_ready,
    input  logic         req_axis_tuser,
    input  logic [127:0] req_axis_data,
    output logic         resp_axis_valid,
    input  logic         resp_axis_ready,
    output logic         resp_axis_tuser,
    output logic [127:0] resp_axis_data,
    output logic [26:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic [15:0]  app_wdf_mask,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid
);
    localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

    state_t          state, state_nxt;
    channel_update_t hdr, in_hdr;
    logic [26:0]     idx;
    logic [26:0]     word;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic [128:0]    fifo_din, fifo_dout;
    logic            last_beat, credit_ok, ack_ok;
    logic            hdr_hs, beat_hs, beat_ok, issue, rd_push, ack_push;

    assign in_hdr    = req_axis_data[54:0];
    assign word      = hdr.addr + idx;
    assign app_addr  = word << ADDR_SHIFT;
    assign last_beat = (idx == hdr.stream_length - 27'd1);
    // Reads in flight plus buffered beats may never exceed the FIFO size.
    assign credit_ok = !fifo_full &&
                       (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(RD_FIFO_DEPTH));
    assign rd_push   = app_rd_data_valid && (outstanding != '0);

`ifdef MEM_WRITE_ACK_EN
    // Holding the ack until earlier reads have returned keeps responses in issue order.
    assign ack_ok = credit_ok && (outstanding == '0);
`else
    assign ack_ok = 1'b1;
`endif

    assign app_wdf_data = req_axis_data;
    assign app_wdf_mask = '0;
    assign app_wdf_end  = app_wdf_wren;

    always_comb begin
        state_nxt      = state;
        req_axis_ready = 1'b0;
        app_en         = 1'b0;
        app_wdf_wren   = 1'b0;
        app_cmd        = APP_CMD_WR;
        hdr_hs         = 1'b0;
        beat_hs        = 1'b0;
        beat_ok        = 1'b0;
        issue          = 1'b0;
        ack_push       = 1'b0;
        if (rst_n_in) begin
            case (state)
                IDLE: begin
                    req_axis_ready = 1'b1;
                    if (req_axis_valid && req_axis_tuser) begin
                        hdr_hs = 1'b1;
                        if (in_hdr.stream_length != '0)
                            state_nxt = in_hdr.wen ? WR : RD;
                    end
                end
                WR: begin
                    beat_ok        = app_rdy && app_wdf_rdy && (!last_beat || ack_ok);
                    req_axis_ready = beat_ok;
                    beat_hs        = req_axis_valid && beat_ok;
                    app_en         = beat_hs;
                    app_wdf_wren   = beat_hs;
                    if (beat_hs && last_beat) begin
                        state_nxt = IDLE;
`ifdef MEM_WRITE_ACK_EN
                        ack_push  = 1'b1;
`endif
                    end
                end
                RD: begin
                    app_cmd = APP_CMD_RD;
                    app_en  = credit_ok;
                    issue   = credit_ok && app_rdy;
                    if (issue && last_beat) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            hdr         <= '0;
            idx         <= '0;
            outstanding <= '0;
        end else begin
            if (hdr_hs) begin
                hdr <= in_hdr;
                idx <= '0;
            end else if (beat_hs || issue) begin
                idx <= idx + 27'd1;
            end
            outstanding <= outstanding + CW'(issue) - CW'(rd_push);
        end
    end

    assign fifo_din = rd_push ? {1'b0, app_rd_data} : {1'b1, 128'd0};

    sync_fifo #(.WIDTH(129), .DEPTH(RD_FIFO_DEPTH)) u_rd_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (rd_push || ack_push),
        .push_data (fifo_din),
        .pop       (resp_axis_valid && resp_axis_ready),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign resp_axis_valid = !fifo_empty;
    assign resp_axis_data  = fifo_dout[127:0];
    assign resp_axis_tuser = !fifo_empty && fifo_dout[128];

endmodule

// File: tb/tb_axis_mem_cmd.sv
// Directed + randomized bench for axis_mem_cmd with a MIG stand-in returning read data 3 cycles after issue.
module tb_axis_mem_cmd;
    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         req_axis_valid, req_axis_ready, req_axis_tuser;
    logic [127:0] req_axis_data;
    logic         resp_axis_valid, resp_axis_ready, resp_axis_tuser;
    logic [127:0] resp_axis_data;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;

    always #5 clk_in = ~clk_in;

    axis_mem_cmd dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_axis_valid(req_axis_valid), .req_axis_ready(req_axis_ready),
        .req_axis_tuser(req_axis_tuser), .req_axis_data(req_axis_data),
        .resp_axis_valid(resp_axis_valid), .resp_axis_ready(resp_axis_ready),
        .resp_axis_tuser(resp_axis_tuser), .resp_axis_data(resp_axis_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    typedef struct {int due; logic [26:0] a;} ret_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           en_cnt, vld_cnt;
    bit           acc, rdy_toggle, rnd_rdy;
    ret_t         ret_q[$];
    logic [26:0]  rd_log[$];
    logic [26:0]  wr_addr_log[$];
    logic [2:0]   wr_cmd_log[$];
    logic [127:0] wr_data_log[$];
    logic [128:0] resp_log[$];
    int           resp_cyc[$];
    int           ret_cyc[$];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rdata(input logic [26:0] a);
        return {32'hD00D0000 | 32'(a), ~{5'd0, a}, 32'(a) * 32'h9E3779B1, 32'(a) ^ 32'h5A5A5A5A};
    endfunction

    function automatic logic [127:0] hdr(input logic [26:0] a, input logic [26:0] l, input logic w);
        return {73'd0, a, l, w};
    endfunction

    function automatic logic [26:0] mig_addr(input logic [26:0] base, input int i);
        logic [26:0] w;
        w = base + 27'(i);
        return w << 3;
    endfunction

    task automatic clear_logs();
        rd_log.delete(); wr_addr_log.delete(); wr_cmd_log.delete(); wr_data_log.delete();
        resp_log.delete(); resp_cyc.delete(); ret_cyc.delete();
        en_cnt = 0; vld_cnt = 0;
    endtask

    // One clock cycle: drive MIG-side inputs, observe mid-cycle, advance to next negedge.
    task automatic tick();
        if (rdy_toggle) app_rdy = ~app_rdy;
        if (rnd_rdy) begin
            app_rdy         = 1'($urandom_range(0, 1));
            app_wdf_rdy     = 1'($urandom_range(0, 1));
            resp_axis_ready = 1'($urandom_range(0, 1));
        end
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = rdata(ret_q[0].a);
            ret_cyc.push_back(cyc);
            ret_q.delete(0);
        end else begin
            app_rd_data_valid = 1'b0;
            app_rd_data       = '0;
        end
        #1;
        acc = req_axis_valid && req_axis_ready;
        if (app_en) en_cnt++;
        if (resp_axis_valid) vld_cnt++;
        if (app_en && app_rdy) begin
            if (app_cmd == 3'b001) begin
                rd_log.push_back(app_addr);
                ret_q.push_back('{cyc + 3, app_addr});
            end else begin
                wr_addr_log.push_back(app_addr);
                wr_cmd_log.push_back(app_cmd);
            end
        end
        if (app_wdf_wren && app_wdf_rdy) wr_data_log.push_back(app_wdf_data);
        if (resp_axis_valid && resp_axis_ready) begin
            resp_log.push_back({resp_axis_tuser, resp_axis_data});
            resp_cyc.push_back(cyc);
        end
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic tu, input logic [127:0] d);
        int n = 0;
        req_axis_valid = 1'b1;
        req_axis_tuser = tu;
        req_axis_data  = d;
        acc = 1'b0;
        while (!acc && n < 200) begin
            tick();
            n++;
        end
        req_axis_valid = 1'b0;
        req_axis_tuser = 1'b0;
        chk("send_accept", 160'(acc), 160'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0]  a, b;
        logic [127:0] d[4];
        logic [26:0]  exp_rd[$];
        logic [26:0]  exp_wa[$];
        logic [127:0] exp_wd[$];
        logic [128:0] exp_resp[$];
        int           len, n;
        logic         w;

        rst_n_in = 1'b0; req_axis_valid = 1'b0; req_axis_tuser = 1'b0; req_axis_data = '0;
        resp_axis_ready = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data = '0; app_rd_data_valid = 1'b0;
        rdy_toggle = 1'b0; rnd_rdy = 1'b0;
        @(negedge clk_in);
        idle(2);

        // Reset state
        chk("rst_req_ready", 160'(req_axis_ready), 160'(0));
        chk("rst_app_en", 160'(app_en), 160'(0));
        chk("rst_wdf_wren", 160'(app_wdf_wren), 160'(0));
        chk("rst_resp_valid", 160'(resp_axis_valid), 160'(0));
        chk("rst_app_addr", 160'(app_addr), 160'(0));
        chk("rst_app_cmd", 160'(app_cmd), 160'(0));
        rst_n_in = 1'b1;
        #1;
        chk("idle_req_ready", 160'(req_axis_ready), 160'(1));

        // Write, MIG always ready
        clear_logs();
        a = 27'h10;
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
        send(1'b1, hdr(a, 27'd4, 1'b1));
        for (int i = 0; i < 4; i++) send(1'b0, d[i]);
        idle(10);
        chk("wr_cmd_count", 160'(wr_addr_log.size()), 160'(4));
        chk("wr_data_count", 160'(wr_data_log.size()), 160'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr_log.size()) begin
                chk("wr_addr", 160'(wr_addr_log[i]), 160'(27'h80 + 27'(8 * i)));
                chk("wr_cmd", 160'(wr_cmd_log[i]), 160'(3'b000));
            end
            if (i < wr_data_log.size()) chk("wr_data", 160'(wr_data_log[i]), 160'(d[i]));
        end
`ifdef MEM_WRITE_ACK_EN
        chk("wr_ack_count", 160'(resp_log.size()), 160'(1));
        if (resp_log.size() > 0) chk("wr_ack_beat", 160'(resp_log[0]), 160'({1'b1, 128'd0}));
`else
        chk("wr_no_resp", 160'(resp_log.size()), 160'(0));
`endif

        // Read with app_rdy toggling, address wrap
        clear_logs();
        rdy_toggle = 1'b1;
        send(1'b1, hdr(27'h7FFFFFF, 27'd4, 1'b0));
        idle(30);
        rdy_toggle = 1'b0;
        app_rdy = 1'b1;
        chk("rdwrap_cmd_count", 160'(rd_log.size()), 160'(4));
        chk("rdwrap_resp_count", 160'(resp_log.size()), 160'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < rd_log.size()) chk("rdwrap_addr", 160'(rd_log[i]), 160'(mig_addr(27'h7FFFFFF, i)));
            if (i < resp_log.size()) begin
                chk("rdwrap_data", 160'(resp_log[i]), 160'({1'b0, rdata(mig_addr(27'h7FFFFFF, i))}));
                if (i < ret_cyc.size()) chk("rdwrap_latency", 160'(resp_cyc[i]), 160'(ret_cyc[i] + 1));
            end
        end

        // Response backpressure limits outstanding reads
        clear_logs();
        resp_axis_ready = 1'b0;
        a = 27'($urandom);
        send(1'b1, hdr(a, 27'd20, 1'b0));
        idle(40);
        chk("bp_issued", 160'(rd_log.size()), 160'(16));
        chk("bp_app_en_low", 160'(app_en), 160'(0));
        chk("bp_resp_valid", 160'(resp_axis_valid), 160'(1));
        resp_axis_ready = 1'b1;
        idle(80);
        chk("bp_cmd_total", 160'(rd_log.size()), 160'(20));
        chk("bp_resp_total", 160'(resp_log.size()), 160'(20));
        for (int i = 0; i < 20; i++) begin
            if (i < rd_log.size()) chk("bp_addr", 160'(rd_log[i]), 160'(mig_addr(a, i)));
            if (i < resp_log.size()) chk("bp_data", 160'(resp_log[i]), 160'({1'b0, rdata(mig_addr(a, i))}));
        end

        // Zero-length header and stray data beat in IDLE
        clear_logs();
        send(1'b1, hdr(27'($urandom), 27'd0, 1'b1));
        send(1'b0, {$urandom, $urandom, $urandom, $urandom});
        idle(3);
        chk("zl_no_app_en", 160'(en_cnt), 160'(0));
        app_rdy = 1'b0;
        #1;
        chk("zl_still_idle", 160'(req_axis_ready), 160'(1));
        app_rdy = 1'b1;

        // Reset in the middle of a read
        clear_logs();
        a = 27'($urandom);
        send(1'b1, hdr(a, 27'd8, 1'b0));
        n = 0;
        while (rd_log.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        idle(10);
        chk("mr_cmd_count", 160'(rd_log.size()), 160'(3));
        chk("mr_no_valid", 160'(vld_cnt), 160'(0));
        chk("mr_no_resp", 160'(resp_log.size()), 160'(0));
        clear_logs();
        b = 27'($urandom);
        d[0] = {$urandom, $urandom, $urandom, $urandom};
        d[1] = {$urandom, $urandom, $urandom, $urandom};
        send(1'b1, hdr(b, 27'd2, 1'b1));
        send(1'b0, d[0]);
        send(1'b0, d[1]);
        idle(5);
        chk("mr_wr_count", 160'(wr_addr_log.size()), 160'(2));
        for (int i = 0; i < 2; i++) begin
            if (i < wr_addr_log.size()) chk("mr_wr_addr", 160'(wr_addr_log[i]), 160'(mig_addr(b, i)));
            if (i < wr_data_log.size()) chk("mr_wr_data", 160'(wr_data_log[i]), 160'(d[i]));
        end

        // Randomized mix of reads and writes with random handshakes
        clear_logs();
        rnd_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            a   = 27'($urandom);
            send(1'b1, hdr(a, 27'(len), w));
            for (int i = 0; i < len; i++) begin
                if (w) begin
                    d[0] = {$urandom, $urandom, $urandom, $urandom};
                    send(1'b0, d[0]);
                    exp_wa.push_back(mig_addr(a, i));
                    exp_wd.push_back(d[0]);
                end else begin
                    exp_rd.push_back(mig_addr(a, i));
                    exp_resp.push_back({1'b0, rdata(mig_addr(a, i))});
                end
            end
`ifdef MEM_WRITE_ACK_EN
            if (w) exp_resp.push_back({1'b1, 128'd0});
`endif
        end
        idle(150);
        rnd_rdy = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; resp_axis_ready = 1'b1;
        idle(30);
        chk("rnd_rd_count", 160'(rd_log.size()), 160'(exp_rd.size()));
        chk("rnd_wr_count", 160'(wr_addr_log.size()), 160'(exp_wa.size()));
        chk("rnd_resp_count", 160'(resp_log.size()), 160'(exp_resp.size()));
        foreach (exp_rd[i]) if (i < rd_log.size()) chk("rnd_rd_addr", 160'(rd_log[i]), 160'(exp_rd[i]));
        foreach (exp_wa[i]) begin
            if (i < wr_addr_log.size()) chk("rnd_wr_addr", 160'(wr_addr_log[i]), 160'(exp_wa[i]));
            if (i < wr_data_log.size()) chk("rnd_wr_data", 160'(wr_data_log[i]), 160'(exp_wd[i]));
        end
        foreach (exp_resp[i]) if (i < resp_log.size()) chk("rnd_resp", 160'(resp_log[i]), 160'(exp_resp[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
